// File: rtl/alu_pkg.sv
// Shared ALU definitions: opcode constants and the multiply sequencer state encoding.
package alu_pkg;

   localparam logic [2:0] ALU_ADD = 3'b000;
   localparam logic [2:0] ALU_SUB = 3'b001;
   localparam logic [2:0] ALU_AND = 3'b010;
   localparam logic [2:0] ALU_OR  = 3'b011;
   localparam logic [2:0] ALU_XOR = 3'b100;
   localparam logic [2:0] ALU_NOT = 3'b101;
   localparam logic [2:0] ALU_SHL = 3'b110;
   localparam logic [2:0] ALU_SHR = 3'b111;

   typedef enum logic [1:0] {
      StIdle  = 2'd0,
      StAdd   = 2'd1,
      StShift = 2'd2,
      StDone  = 2'd3
   } mul_state_e;

endpackage

// File: rtl/alu_mul_seq_if.sv
// Operand/product handshake bundle between the CPU execute stage and alu_mul_seq.
interface alu_mul_seq_if;

   logic        in_valid;
   logic        in_ready;
   logic [7:0]  mcand;
   logic [7:0]  mplier;
   logic        out_valid;
   logic        out_ready;
   logic [15:0] product;

   modport master (
      output in_valid, mcand, mplier, out_ready,
      input  in_ready, out_valid, product
   );

   modport slave (
      input  in_valid, mcand, mplier, out_ready,
      output in_ready, out_valid, product
   );

endinterface

// File: rtl/alu.sv
// 8-bit combinational ALU shared with the multiply sequencer.
module alu
   import alu_pkg::*;
(
   input  logic [7:0] a,
   input  logic [7:0] b,
   input  logic [2:0] op,
   output logic [7:0] s,
   output logic       c
);

   logic [8:0] sum;
   logic [8:0] diff;

   assign sum  = {1'b0, a} + {1'b0, b};
   // Carry on subtract means "no borrow".
   assign diff = {1'b0, a} + {1'b0, ~b} + 9'd1;

   always_comb begin
      s = 8'h00;
      c = 1'b0;
      unique case (op)
         ALU_ADD: {c, s} = sum;
         ALU_SUB: {c, s} = diff;
         ALU_AND: s = a & b;
         ALU_OR:  s = a | b;
         ALU_XOR: s = a ^ b;
         ALU_NOT: s = ~a;
         ALU_SHL: begin s = {a[6:0], 1'b0}; c = a[7]; end
         ALU_SHR: begin s = {1'b0, a[7:1]}; c = a[0]; end
         default: s = 8'h00;
      endcase
   end

endmodule

// File: rtl/alu_mul_seq.sv
// Shift-add 8x8->16 unsigned multiply sequencer driving an external ALU.
// Optional ALU_MUL_SKIP_EN skips the ADD step for multiplier bits that are 0.
module alu_mul_seq
   import alu_pkg::*;
(
   input  logic         clk,
   input  logic         rst_n,
   alu_mul_seq_if.slave bus,
   output logic [7:0]   alu_a,
   output logic [7:0]   alu_b,
   output logic [2:0]   alu_op,
   input  logic [7:0]   alu_s,
   input  logic         alu_c
);

`ifdef ALU_MUL_SKIP_EN
   localparam bit SkipEn = 1'b1;
`else
   localparam bit SkipEn = 1'b0;
`endif

   mul_state_e state;
   logic [7:0] m;
   logic [7:0] hi;
   logic [7:0] lo;
   logic [3:0] cnt;
   logic       cy;
   logic       in_ready;
   logic       out_valid;
   logic [7:0] shift_hi;

   // The ALU shifts a 0 into bit 7; the saved add carry replaces it.
   assign shift_hi = {cy, alu_s[6:0]};

   assign bus.in_ready  = in_ready;
   assign bus.out_valid = out_valid;
   assign bus.product   = {hi, lo};

   // ALU drive registers are loaded with the values the next state needs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= StIdle;
         m         <= 8'h00;
         hi        <= 8'h00;
         lo        <= 8'h00;
         cnt       <= 4'd0;
         cy        <= 1'b0;
         in_ready  <= 1'b1;
         out_valid <= 1'b0;
         alu_a     <= 8'h00;
         alu_b     <= 8'h00;
         alu_op    <= ALU_ADD;
      end else begin
         unique case (state)
            StIdle: begin
               if (bus.in_valid) begin
                  m        <= bus.mcand;
                  hi       <= 8'h00;
                  lo       <= bus.mplier;
                  cnt      <= 4'd0;
                  cy       <= 1'b0;
                  in_ready <= 1'b0;
                  alu_a    <= 8'h00;
                  if (SkipEn && !bus.mplier[0]) begin
                     state  <= StShift;
                     alu_op <= ALU_SHR;
                     alu_b  <= 8'h00;
                  end else begin
                     state  <= StAdd;
                     alu_op <= ALU_ADD;
                     alu_b  <= bus.mplier[0] ? bus.mcand : 8'h00;
                  end
               end
            end
            StAdd: begin
               hi     <= alu_s;
               cy     <= alu_c;
               state  <= StShift;
               alu_a  <= alu_s;
               alu_b  <= 8'h00;
               alu_op <= ALU_SHR;
            end
            StShift: begin
               hi  <= shift_hi;
               lo  <= {hi[0], lo[7:1]};
               cy  <= 1'b0;
               cnt <= cnt + 4'd1;
               if (cnt == 4'd7) begin
                  state     <= StDone;
                  out_valid <= 1'b1;
                  alu_a     <= 8'h00;
                  alu_b     <= 8'h00;
                  alu_op    <= ALU_ADD;
               end else if (SkipEn && !lo[1]) begin
                  state  <= StShift;
                  alu_a  <= shift_hi;
                  alu_b  <= 8'h00;
                  alu_op <= ALU_SHR;
               end else begin
                  state  <= StAdd;
                  alu_a  <= shift_hi;
                  alu_b  <= lo[1] ? m : 8'h00;
                  alu_op <= ALU_ADD;
               end
            end
            StDone: begin
               if (bus.out_ready) begin
                  state     <= StIdle;
                  out_valid <= 1'b0;
                  in_ready  <= 1'b1;
               end
            end
            default: state <= StIdle;
         endcase
      end
   end

endmodule
